// File: rtl/soma_scan_ctrl.sv
// soma_scan_ctrl: timestep scan sequencer feeding the soma update pipe,
// with a credit-gated spike FIFO collecting neurons that fired.
// Ports:
//   clk_soma, rst            - sole clock, synchronous active-high reset
//   scan_start/last/clear    - scan request, latched when accepted in IDLE
//   scan_busy, scan_done     - not-IDLE flag, one-cycle end-of-scan pulse
//   config_soma_*            - per-neuron strobe, index and clear flag
//   soma_spk_out_fire        - soma fire result, one cycle after the strobe
//   spk_valid/addr/ready     - spike FIFO head handshake
//   spk_count                - FIFO occupancy
module soma_scan_ctrl #(
  parameter int NNW = 12,
  parameter int FD  = 8,
  parameter int FAW = 3
) (
  input  logic           clk_soma,
  input  logic           rst,
  input  logic           scan_start,
  input  logic [NNW-1:0] scan_last,
  input  logic           scan_clear,
  output logic           scan_busy,
  output logic           scan_done,
  output logic           config_soma_vld,
  output logic [NNW-1:0] config_soma_vm_addr,
  output logic           config_soma_clear,
  input  logic           soma_spk_out_fire,
  output logic           spk_valid,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_ready,
  output logic [FAW:0]   spk_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [FAW+1:0] FD_V = (FAW+2)'(FD);
  localparam logic [FAW:0]   CNT1 = (FAW+1)'(1);
  localparam logic [FAW-1:0] PTR1 = FAW'(1);
  localparam logic [NNW-1:0] IDX1 = NNW'(1);

  state_t         state;
  logic [NNW-1:0] idx;
  logic [NNW-1:0] last_q;
  logic           clr_q;
  logic           busy_q;
  logic           done_q;

  logic           cap_vld;
  logic           cap_clr;
  logic [NNW-1:0] cap_addr;

  logic [NNW-1:0] mem [FD];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   count;

  logic           inflight;
  logic [FAW+1:0] occ;
  logic           credit;
  logic           push;
  logic           pop;

  // A strobe of a non-clear pass may still turn into a push next
  // cycle, so it reserves a FIFO slot. Pops are deliberately not
  // counted as freeing a slot until they have happened.
  assign inflight = cap_vld & ~cap_clr;
  assign occ      = {1'b0, count}
                  + {{(FAW+1){1'b0}}, inflight};
  assign credit   = occ < FD_V;

  assign config_soma_vld     = (state == SCAN) & credit;
  assign config_soma_vm_addr = idx;
  assign config_soma_clear   = clr_q;
  assign scan_busy           = busy_q;
  assign scan_done           = done_q;

  assign push      = cap_vld & ~cap_clr & soma_spk_out_fire;
  assign spk_valid = (count != '0);
  assign pop       = spk_valid & spk_ready;
  assign spk_addr  = spk_valid ? mem[rd_ptr] : '0;
  assign spk_count = count;

  always_ff @(posedge clk_soma) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      last_q <= '0;
      clr_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start) begin
            state  <= SCAN;
            idx    <= '0;
            last_q <= scan_last;
            clr_q  <= scan_clear;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          // Compare before incrementing so a full-range scan
          // never wraps idx back to zero.
          if (config_soma_vld) begin
            if (idx == last_q) begin
              state <= DRAIN;
            end else begin
              idx <= idx + IDX1;
            end
          end
        end
        DRAIN: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_soma) begin
    if (rst) begin
      cap_vld  <= 1'b0;
      cap_clr  <= 1'b0;
      cap_addr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      cap_vld  <= config_soma_vld;
      cap_clr  <= clr_q;
      cap_addr <= idx;
      if (push) begin
        wr_ptr <= wr_ptr + PTR1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_soma) begin
    if (!rst && push) begin
      mem[wr_ptr] <= cap_addr;
    end
  end

endmodule

// File: tb/tb_soma_scan_ctrl.sv
// tb_soma_scan_ctrl: directed bench for soma_scan_ctrl.
// A small soma model answers strobes; a monitor logs strobes/pops/done.
module tb_soma_scan_ctrl;

  localparam int NNW = 12;
  localparam int FD  = 8;
  localparam int FAW = 3;

  logic           clk_soma = 1'b0;
  logic           rst;
  logic           scan_start;
  logic [NNW-1:0] scan_last;
  logic           scan_clear;
  logic           scan_busy;
  logic           scan_done;
  logic           config_soma_vld;
  logic [NNW-1:0] config_soma_vm_addr;
  logic           config_soma_clear;
  logic           soma_spk_out_fire;
  logic           spk_valid;
  logic [NNW-1:0] spk_addr;
  logic           spk_ready;
  logic [FAW:0]   spk_count;

  logic        fire_all;
  logic [15:0] fire_mask;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int max_count;
  int strobe_q[$];
  int strobe_cyc[$];
  int strobe_clr[$];
  int pop_q[$];
  int done_q[$];

  soma_scan_ctrl #(.NNW(NNW), .FD(FD), .FAW(FAW)) dut (
    .clk_soma            (clk_soma),
    .rst                 (rst),
    .scan_start          (scan_start),
    .scan_last           (scan_last),
    .scan_clear          (scan_clear),
    .scan_busy           (scan_busy),
    .scan_done           (scan_done),
    .config_soma_vld     (config_soma_vld),
    .config_soma_vm_addr (config_soma_vm_addr),
    .config_soma_clear   (config_soma_clear),
    .soma_spk_out_fire   (soma_spk_out_fire),
    .spk_valid           (spk_valid),
    .spk_addr            (spk_addr),
    .spk_ready           (spk_ready),
    .spk_count           (spk_count)
  );

  always #5 clk_soma = ~clk_soma;

  // Soma answers each strobe one cycle later.
  always @(posedge clk_soma) begin
    soma_spk_out_fire <= fire_all
      | (config_soma_vld & fire_mask[config_soma_vm_addr[3:0]]);
  end

  always @(negedge clk_soma) begin
    cyc++;
    if (config_soma_vld) begin
      strobe_q.push_back(int'(config_soma_vm_addr));
      strobe_cyc.push_back(cyc);
      strobe_clr.push_back(int'(config_soma_clear));
    end
    if (spk_valid && spk_ready) pop_q.push_back(int'(spk_addr));
    if (scan_done) done_q.push_back(cyc);
    if (int'(spk_count) > max_count) max_count = int'(spk_count);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_soma);
    #1;
  endtask

  task automatic clear_log();
    strobe_q.delete();
    strobe_cyc.delete();
    strobe_clr.delete();
    pop_q.delete();
    done_q.delete();
    max_count = 0;
  endtask

  task automatic start_scan(input logic [NNW-1:0] last, input logic clr);
    scan_last  = last;
    scan_clear = clr;
    scan_start = 1'b1;
    tick(1);
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick(1);
      if (scan_done) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout got no scan_done in %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if (scan_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", scan_busy);
    end
    checks++;
    if (scan_done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", scan_done);
    end
    checks++;
    if (config_soma_vld !== 1'b0) begin
      failures++; $display("FAIL reset_vld got=%b exp=0", config_soma_vld);
    end
    checks++;
    if (config_soma_vm_addr !== '0) begin
      failures++; $display("FAIL reset_vm_addr got=%0d exp=0", config_soma_vm_addr);
    end
    checks++;
    if (spk_valid !== 1'b0) begin
      failures++; $display("FAIL reset_spk_valid got=%b exp=0", spk_valid);
    end
    checks++;
    if (spk_count !== '0) begin
      failures++; $display("FAIL reset_spk_count got=%0d exp=0", spk_count);
    end
    checks++;
    if (spk_addr !== '0) begin
      failures++; $display("FAIL reset_spk_addr got=%0d exp=0", spk_addr);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    clear_log();
    fire_all  = 1'b0;
    fire_mask = 16'h000A;
    spk_ready = 1'b1;
    start_scan(3, 1'b0);
    wait_done(20, "basic");
    tick(3);
    checks++;
    if (strobe_q.size() != 4) begin
      failures++; $display("FAIL basic_strobe_n got=%0d exp=4", strobe_q.size());
    end
    for (int i = 0; i < 4 && i < strobe_q.size(); i++) begin
      checks++;
      if (strobe_q[i] != i || strobe_cyc[i] != strobe_cyc[0] + i) begin
        failures++;
        $display("FAIL basic_strobe[%0d] got=%0d@%0d exp=%0d@%0d",
                 i, strobe_q[i], strobe_cyc[i], i, strobe_cyc[0] + i);
      end
    end
    checks++;
    if (pop_q.size() != 2) begin
      failures++; $display("FAIL basic_pop_n got=%0d exp=2", pop_q.size());
    end else begin
      checks++;
      if (pop_q[0] != 1 || pop_q[1] != 3) begin
        failures++;
        $display("FAIL basic_pops got=%0d,%0d exp=1,3", pop_q[0], pop_q[1]);
      end
    end
    checks++;
    if (done_q.size() != 1 || strobe_cyc.size() != 4
        || done_q[0] != strobe_cyc[3] + 2) begin
      failures++;
      $display("FAIL basic_done_timing got_n=%0d exp one pulse 2 after last strobe",
               done_q.size());
    end
  endtask

  task automatic test_clear_pass();
    clear_log();
    fire_all  = 1'b1;
    spk_ready = 1'b1;
    start_scan(5, 1'b1);
    wait_done(20, "clear");
    tick(3);
    checks++;
    if (strobe_q.size() != 6) begin
      failures++; $display("FAIL clear_strobe_n got=%0d exp=6", strobe_q.size());
    end
    for (int i = 0; i < strobe_q.size(); i++) begin
      checks++;
      if (strobe_clr[i] != 1 || strobe_q[i] != i) begin
        failures++;
        $display("FAIL clear_strobe[%0d] got addr=%0d clr=%0d exp addr=%0d clr=1",
                 i, strobe_q[i], strobe_clr[i], i);
      end
    end
    checks++;
    if (max_count != 0 || pop_q.size() != 0) begin
      failures++;
      $display("FAIL clear_no_push got max_count=%0d pops=%0d exp 0,0",
               max_count, pop_q.size());
    end
    checks++;
    if (done_q.size() != 1) begin
      failures++; $display("FAIL clear_done_n got=%0d exp=1", done_q.size());
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    fire_all  = 1'b1;
    spk_ready = 1'b0;
    start_scan(15, 1'b0);
    tick(14);
    checks++;
    if (strobe_q.size() != 8) begin
      failures++; $display("FAIL bp_stall_strobes got=%0d exp=8", strobe_q.size());
    end
    checks++;
    if (spk_count !== 4'd8) begin
      failures++; $display("FAIL bp_count_full got=%0d exp=8", spk_count);
    end
    checks++;
    if (config_soma_vld !== 1'b0 || scan_busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_stalled got vld=%b busy=%b exp vld=0 busy=1",
               config_soma_vld, scan_busy);
    end
    spk_ready = 1'b1;
    wait_done(40, "bp");
    tick(10);
    checks++;
    if (strobe_q.size() != 16 || strobe_q[8] != 8) begin
      failures++;
      $display("FAIL bp_resume got n=%0d [8]=%0d exp n=16 [8]=8",
               strobe_q.size(), strobe_q[8]);
    end
    checks++;
    if (pop_q.size() != 16) begin
      failures++; $display("FAIL bp_pop_n got=%0d exp=16", pop_q.size());
    end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] != i) begin
        failures++; $display("FAIL bp_pop[%0d] got=%0d exp=%0d", i, pop_q[i], i);
      end
    end
    checks++;
    if (max_count != 8) begin
      failures++; $display("FAIL bp_max_count got=%0d exp=8", max_count);
    end
    checks++;
    if (done_q.size() != 1 || spk_count !== '0) begin
      failures++;
      $display("FAIL bp_end got done_n=%0d count=%0d exp 1,0",
               done_q.size(), spk_count);
    end
  endtask

  task automatic test_ptr_wrap();
    bit hit = 0;
    clear_log();
    fire_all  = 1'b1;
    spk_ready = 1'b0;
    start_scan(15, 1'b0);
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_soma);
      if (spk_count == 4'd3) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL wrap_fill got no spk_count=3 exp reached");
    end
    tick(1);
    spk_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (spk_count !== 4'd4) begin
        failures++;
        $display("FAIL wrap_count[%0d] got=%0d exp=4", i, spk_count);
      end
      tick(1);
    end
    wait_done(30, "wrap");
    tick(6);
    checks++;
    if (pop_q.size() != 16) begin
      failures++; $display("FAIL wrap_pop_n got=%0d exp=16", pop_q.size());
    end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] != i) begin
        failures++; $display("FAIL wrap_pop[%0d] got=%0d exp=%0d", i, pop_q[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    fire_all  = 1'b1;
    spk_ready = 1'b0;
    start_scan(10, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (scan_busy !== 1'b0 || spk_valid !== 1'b0 || spk_count !== '0) begin
      failures++;
      $display("FAIL rstmid_abort got busy=%b valid=%b count=%0d exp 0,0,0",
               scan_busy, spk_valid, spk_count);
    end
    tick(4);
    checks++;
    if (done_q.size() != 0) begin
      failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_q.size());
    end
    checks++;
    if (spk_count !== '0 || config_soma_vld !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_capture got count=%0d vld=%b exp 0,0",
               spk_count, config_soma_vld);
    end
    clear_log();
    spk_ready = 1'b1;
    start_scan(3, 1'b0);
    wait_done(20, "rstmid");
    tick(3);
    checks++;
    if (strobe_q.size() != 4 || strobe_q[0] != 0) begin
      failures++;
      $display("FAIL rstmid_restart got n=%0d first=%0d exp n=4 first=0",
               strobe_q.size(), strobe_q[0]);
    end
    checks++;
    if (pop_q.size() != 4 || pop_q[0] != 0 || pop_q[3] != 3) begin
      failures++;
      $display("FAIL rstmid_pops got n=%0d exp 0..3", pop_q.size());
    end
  endtask

  task automatic test_restart_ignored();
    clear_log();
    fire_all  = 1'b0;
    fire_mask = 16'h0000;
    spk_ready = 1'b1;
    start_scan(6, 1'b0);
    tick(2);
    scan_start = 1'b1;
    scan_last  = 12'd2;
    scan_clear = 1'b1;
    tick(1);
    scan_start = 1'b0;
    wait_done(20, "restart");
    tick(2);
    checks++;
    if (strobe_q.size() != 7) begin
      failures++; $display("FAIL restart_strobe_n got=%0d exp=7", strobe_q.size());
    end
    for (int i = 0; i < strobe_q.size(); i++) begin
      checks++;
      if (strobe_q[i] != i || strobe_clr[i] != 0
          || strobe_cyc[i] != strobe_cyc[0] + i) begin
        failures++;
        $display("FAIL restart_strobe[%0d] got addr=%0d clr=%0d exp addr=%0d clr=0",
                 i, strobe_q[i], strobe_clr[i], i);
      end
    end
    checks++;
    if (done_q.size() != 1 || strobe_cyc.size() != 7
        || done_q[0] != strobe_cyc[6] + 2) begin
      failures++;
      $display("FAIL restart_done got n=%0d exp one pulse 2 after strobe 6",
               done_q.size());
    end
  endtask

  task automatic test_last_bounds();
    bit seq_ok = 1;
    clear_log();
    fire_all  = 1'b0;
    fire_mask = 16'h0000;
    spk_ready = 1'b1;
    start_scan(0, 1'b0);
    wait_done(10, "last0");
    tick(2);
    checks++;
    if (strobe_q.size() != 1 || strobe_q[0] != 0) begin
      failures++;
      $display("FAIL last0_strobes got n=%0d exp n=1 addr=0", strobe_q.size());
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != strobe_cyc[0] + 2) begin
      failures++; $display("FAIL last0_done got n=%0d exp=1", done_q.size());
    end
    clear_log();
    start_scan(12'hFFF, 1'b0);
    wait_done(5000, "lastmax");
    tick(2);
    checks++;
    if (strobe_q.size() != 4096) begin
      failures++; $display("FAIL lastmax_strobe_n got=%0d exp=4096", strobe_q.size());
    end
    for (int i = 0; i < strobe_q.size(); i++) begin
      if (strobe_q[i] != i) seq_ok = 0;
    end
    checks++;
    if (!seq_ok) begin
      failures++; $display("FAIL lastmax_sequence got out-of-order exp 0..4095");
    end
    checks++;
    if (done_q.size() != 1 || strobe_cyc.size() != 4096
        || done_q[0] != strobe_cyc[4095] + 2) begin
      failures++; $display("FAIL lastmax_done got n=%0d exp=1", done_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    scan_start = 1'b0;
    scan_last  = '0;
    scan_clear = 1'b0;
    spk_ready  = 1'b0;
    fire_all   = 1'b0;
    fire_mask  = 16'h0000;
    max_count  = 0;
    test_reset();
    test_basic();
    test_clear_pass();
    test_backpressure();
    test_ptr_wrap();
    test_reset_mid();
    test_restart_ignored();
    test_last_bounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soma_scan_ctrl.md
SOMA_SCAN_CTRL -- requirements
Module: soma_scan_ctrl

Interface
REQ-001 Parameter NNW, default 12: neuron address width.
REQ-002 Parameter FD, default 8: spike FIFO depth (power of two).
REQ-003 Parameter FAW, default 3: FIFO pointer width, log2(FD).
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk_soma  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 scan_start  in  1  pulse; begins a timestep scan, accepted only in IDLE.
REQ-008 scan_last  in  NNW  index of the last neuron; the scan covers 0..scan_last.
REQ-009 scan_clear  in  1  1 selects a clear pass (Vm zeroed, no spikes).
REQ-010 scan_busy  out  1  high in every state other than IDLE.
REQ-011 scan_done  out  1  one-cycle pulse at the end of a scan.
REQ-012 config_soma_vld  out  1  per-neuron update strobe to the soma.
REQ-013 config_soma_vm_addr  out  NNW  neuron index qualified by config_soma_vld.
REQ-014 config_soma_clear  out  1  clear flag qualified by config_soma_vld.
REQ-015 soma_spk_out_fire  in  1  soma fire result, valid one cycle after config_soma_vld.
REQ-016 spk_valid  out  1  spike FIFO non-empty.
REQ-017 spk_addr  out  NNW  neuron index of the FIFO head entry.
REQ-018 spk_ready  in  1  consumer accepts the head entry when spk_valid is also high.
REQ-019 spk_count  out  FAW+1  current FIFO occupancy.

Function
REQ-020 FSM states SHALL be IDLE, SCAN, DRAIN and DONE.
- IDLE->SCAN on scan_start.
- SCAN->DRAIN in the cycle the strobe for index scan_last is issued.
- DRAIN->DONE after one cycle.
- DONE->IDLE after one cycle.
REQ-021 On scan_start in IDLE, scan_last and scan_clear SHALL be latched; later changes to either have no effect until the next scan.
REQ-022 scan_start outside IDLE SHALL be ignored.
REQ-023 In SCAN, the block SHALL issue one strobe per cycle when credit allows:
- config_soma_vld=1, config_soma_vm_addr=idx, config_soma_clear=latched clear;
- idx then increments by 1.
REQ-024 Credit SHALL be (spk_count + inflight) < FD, where inflight is the registered delayed strobe of a non-clear scan; credit ignores any same-cycle pop.
REQ-025 When credit fails, config_soma_vld SHALL be 0 and idx SHALL hold.
REQ-026 idx SHALL reset to 0 at each scan start.
REQ-027 scan_last=0 SHALL produce exactly one strobe; scan_last=2^NNW-1 SHALL produce 2^NNW strobes with no early wrap.
REQ-028 The capture stage SHALL register the strobe, its address and its clear flag one cycle after issue.
REQ-029 When the captured strobe is 1, its clear flag is 0 and soma_spk_out_fire=1, the captured address SHALL be pushed into the FIFO.
REQ-030 In a clear pass, soma_spk_out_fire SHALL be ignored and no entries pushed.
REQ-031 The FIFO SHALL be synchronous with registered pointers:
- spk_valid = (spk_count != 0);
- spk_addr = entry at the read pointer;
- a push into an empty FIFO becomes visible the next cycle.
REQ-032 Pop SHALL occur on spk_valid && spk_ready.
REQ-033 Simultaneous push and pop SHALL leave spk_count unchanged; both pointers advance modulo FD.
REQ-034 The credit rule SHALL guarantee no push when full; overflow is unreachable by design.
REQ-035 scan_done SHALL be 1 only in DONE, i.e. two cycles after the last strobe.
REQ-036 scan_done SHALL NOT wait for the FIFO to drain; the FIFO keeps operating in all states.
REQ-037 config_soma_vld SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-038 While rst=1, the following SHALL take these values on the clock edge:
- FSM=IDLE, idx=0, pointers=0, spk_count=0;
- capture registers=0;
- all outputs 0.
REQ-039 rst asserted mid-scan SHALL abort the scan with no scan_done pulse, discard FIFO contents, and suppress any pending capture.

Verification
REQ-040 scan_last=3, scan_clear=0, fire only for neurons 1 and 3, spk_ready=1 -> strobes 0,1,2,3 on consecutive cycles; spk_addr 1 then 3; scan_done 2 cycles after strobe 3.
REQ-041 scan_clear=1, scan_last=5, fire held at 1 -> 6 strobes with config_soma_clear=1; no FIFO pushes; scan_done asserted.
REQ-042 scan_last=15, fire always 1, spk_ready=0 -> strobes stall once spk_count+inflight=8; spk_count holds at 8; releasing spk_ready resumes strobes at index 8; all 16 addresses arrive in order.
REQ-043 FIFO holds 4 entries, push and pop every cycle -> spk_count stays 4; read and write pointers wrap past 7 back to 0 without data loss.
REQ-044 rst pulsed in the 3rd cycle of a scan_last=10 scan -> next cycle IDLE, spk_valid=0, no scan_done; a new scan_start then runs from index 0.
REQ-045 scan_start pulsed during SCAN, and scan_last changed mid-scan -> no restart; the scan ends at the latched scan_last.
